uart_peripheral: RTL
====================

# uart_peripheral

Memory-mapped I/O peripheral on the processor's data bus, alongside program memory, providing a byte-transmit UART (8N1) with a small TX FIFO, a status register and a byte-maskable LED register. It consumes the processor's `address`/`writeData`/`writeMask`/`read` bus and returns a registered `readData` that the SOC muxes against memory using `readValid`.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per UART bit (≥2)
- `FIFO_DEPTH`, 4, TX FIFO entries (power of two, ≥2)
- `CLK`  in  1  system clock, all state updates on rising edge
- `RESET`  in  1  asynchronous, active-high reset
- `address`  in  32  byte address from processor
- `writeData`  in  32  store data, already byte-lane aligned by processor
- `writeMask`  in  4  per-byte write enables, nonzero only during store
- `read`  in  1  read request
- `readData`  out  32  registered read data
- `readValid`  out  1  high one cycle after an accepted read of this block
- `TXD`  out  1  UART serial output, idle high
- `LEDS`  out  32  LED register contents

## Operation
- Select: `sel = address[22]`. Register index `address[3:2]`; `address[21:4]`, `address[1:0]` ignored.
- Index 0 TXDATA (W): `sel && writeMask[0]` pushes `writeData[7:0]` if FIFO count < FIFO_DEPTH at that edge; else dropped silently. Other mask bits ignored. Reads return 0.
- Index 1 STATUS (R): bit0 = FIFO full, bit1 = busy (state ≠ IDLE or count ≠ 0), bits[7:4] = FIFO count, rest 0. Writes ignored.
- Index 2 LEDS (R/W): each byte lane i written independently when `sel && writeMask[i]` (all set lanes updated, not first-match).
- Index 3: reads 0, writes ignored.
- Writes with `sel=0` ignored entirely. Register reads never have side effects.
- Read: `sel && read` at an edge → `readData` loaded with selected register value (pre-edge contents), `readValid`=1 for the following cycle. Otherwise `readData` holds, `readValid`=0.
- TX FSM states: IDLE, START, DATA, STOP; bit counter 0..7, cycle counter 0..CLKS_PER_BIT-1.
  - IDLE: TXD=1. If count ≠ 0: pop head into shift register, clear cycle counter → START.
  - START: TXD=0 for CLKS_PER_BIT cycles → DATA, bit counter 0.
  - DATA: TXD=shift[0] (LSB first), each CLKS_PER_BIT cycles shift right, bit counter +1; after bit 7 → STOP.
  - STOP: TXD=1 for CLKS_PER_BIT cycles → IDLE.
- FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH. Push and pop in same edge: both occur, count unchanged.
- Full decision uses pre-edge count: a push on the edge a pop frees the last slot is still dropped.

## Timing
- Reset (async): state IDLE, TXD=1, FIFO empty (pointers, count 0), LEDS=0, readData=0, readValid=0. Reset mid-frame aborts frame; TXD high immediately.
- Read latency 1 cycle, matching program memory.
- TXDATA write at edge N → count=1 after N; pop at N+1; TXD falls after N+1.
- TXD is registered; each bit held exactly CLKS_PER_BIT cycles; frame = 10·CLKS_PER_BIT cycles.
- Back-to-back frames: STOP → IDLE, pop next edge → exactly one idle-high cycle between frames.
- LEDS updates visible the cycle after the write edge.
- STATUS busy clears the cycle after the last STOP cycle if FIFO empty.

## Test plan
- Reset: assert RESET mid-START bit → TXD=1, LEDS=0, STATUS read returns 0x0 after release.
- Single byte: write 0xA5 to 0x400000, CLKS_PER_BIT=4 → TXD low 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, high 4 cycles; busy 1 throughout, 0 after.
- FIFO full: 6 writes (0x01..0x06) on consecutive cycles with DEPTH=4 → 0x01 popped, 0x02..0x05 queued, 0x06 dropped; STATUS bit0=1, count=4; serial output 0x01..0x05 with one idle cycle between frames.
- LED masking: write 0x11223344 mask 1111 to 0x400008, then 0xAABBCCDD mask 0101 → LEDS=0x11BB33DD; read back 0x400008 gives same one cycle later with readValid=1.
- Decode: write to 0x000008 (sel=0) mask 1111 → LEDS unchanged, no FIFO push; read of 0x00000C → readValid=0, readData holds.
- Reads of TXDATA and index 3 return 0; reading STATUS repeatedly does not alter count.

Source files
------------

// File: rtl/uart_peripheral_if.sv
// Processor data-bus view of the UART peripheral: request from the CPU, registered read response back.
interface uart_peripheral_if;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [3:0]  writeMask;
    logic        read;
    logic [31:0] readData;
    logic        readValid;

    modport master (
        output address, writeData, writeMask, read,
        input  readData, readValid
    );

    modport slave (
        input  address, writeData, writeMask, read,
        output readData, readValid
    );
endinterface

// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 transmit UART with a small TX FIFO, a status register and a byte-maskable LED register.
module uart_peripheral #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    uart_peripheral_if.slave  bus,
    output logic              TXD,
    output logic [31:0]       LEDS
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CYC_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_d;
    logic             pop_c;
    logic             last_c;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0]      read_data_q;
    logic             read_valid_q;

    logic             sel_c, push_c, full_c, busy_c;
    logic [1:0]       idx_c;
    logic [31:0]      status_c, rdmux_c;
    logic             unused_addr;

    assign sel_c       = bus.address[22];
    assign idx_c       = bus.address[3:2];
    assign unused_addr = ^{bus.address[31:23], bus.address[21:4], bus.address[1:0]};

    // Full and push decisions use the count as it stands before the edge.
    assign full_c   = (count == CNT_W'(FIFO_DEPTH));
    assign push_c   = sel_c && bus.writeMask[0] && (idx_c == 2'd0) && !full_c;
    assign busy_c   = (state_q != IDLE) || (count != '0);
    assign status_c = {24'b0, 4'(count), 2'b00, busy_c, full_c};
    assign last_c   = (cyc_q == CYC_W'(CLKS_PER_BIT - 1));

    always_comb begin
        rdmux_c = '0;
        case (idx_c)
            2'd1:    rdmux_c = status_c;
            2'd2:    rdmux_c = LEDS;
            default: rdmux_c = '0;
        endcase
    end

    // FIFO storage; entries need no reset since count gates every pop.
    always_ff @(posedge CLK) begin
        if (push_c) fifo_mem[wr_ptr] <= bus.writeData[7:0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_c && !pop_c)      count <= count + CNT_W'(1);
            else if (pop_c && !push_c) count <= count - CNT_W'(1);
        end
    end

    // TX state register; txd_d is the line level for the state being entered.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            TXD     <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            TXD     <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = TXD;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (count != '0) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_mem[rd_ptr];
                    cyc_d   = '0;
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (last_c) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = DATA;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            DATA: begin
                if (last_c) begin
                    cyc_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            STOP: begin
                if (last_c) begin
                    cyc_d   = '0;
                    txd_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // LED lanes and registered read port.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LEDS         <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            if (sel_c && (idx_c == 2'd2)) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.writeMask[i]) LEDS[8*i +: 8] <= bus.writeData[8*i +: 8];
                end
            end
            read_valid_q <= sel_c && bus.read;
            if (sel_c && bus.read) read_data_q <= rdmux_c;
        end
    end

    assign bus.readData  = read_data_q;
    assign bus.readValid = read_valid_q;
endmodule
